fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
Next-PC sequencer for the fetch stage. It drives the PC register's next-address input and its hold control. It arbitrates between sequential fetch, branch, jump, exception entry and eret. It also tracks stalls and instruction-memory waits, and owns the EPC/EXL state needed to return from the exception handler. It sits between the hazard unit, branch/jump resolution, the exception source and the PC register.

Parameters:
RESET_PC, 32'h00003000, PC value forced during reset (matches the PC register reset value)
EXC_VEC, 32'h00004180, exception handler entry address
PC_STEP, 4, sequential increment in bytes

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pc_cur  in  32  current PC from the PC register output
stall  in  1  hazard-unit stall request
imem_ready  in  1  instruction memory has data for pc_cur; 0 = wait
br_taken  in  1  resolved branch taken
br_target  in  32  branch target
jump  in  1  jump (j/jal/jr) resolved
jump_target  in  32  jump target
exc_req  in  1  exception request, single-cycle pulse
exc_pc  in  32  PC of the faulting instruction
eret  in  1  eret executed
pc_next  out  32  next PC, to the PC register data input
pc_hold  out  1  to the PC register enable; 1 = freeze, 0 = load pc_next
flush  out  1  kill younger in-flight instructions
epc  out  32  saved exception PC
exl  out  1  exception level; 1 = in handler
state  out  2  FSM state: RUN=0, HOLD=1, DRAIN=2

Behaviour:
- Only one clock (clk) and one reset (reset). Reset is synchronous and active-high.
- Output timing:
  - pc_next, pc_hold and flush are combinational from the registered state and the current inputs.
  - The PC register samples them at the next clk edge.
- Outputs while reset=1:
  - pc_next=RESET_PC, pc_hold=0, flush=1.
- Register values at the edge where reset=1:
  - state<=RUN, epc<=0, exl<=0, pend_valid<=0, pend_target<=0, pend_eret<=0.
  - Reset mid-HOLD or mid-DRAIN discards the pending redirect.
- Hold condition: hc = stall | ~imem_ready.
- Exception accept: exc_ok = exc_req & ~exl. exc_req while exl=1 is ignored; there is no nesting.
- Redirect priority in one cycle (highest first):
  1. exc_ok
  2. pending redirect (pend_valid)
  3. eret & exl
  4. jump
  5. br_taken
  6. sequential
- Exception accepted (any state, overrides hc):
  - pc_next=EXC_VEC, pc_hold=0, flush=1.
  - At the edge: epc<=exc_pc, exl<=1, pend_valid<=0, state<=DRAIN.
- Held cycle (hc=1, no exc_ok):
  - pc_hold=1, flush=0, pc_next=pc_cur+PC_STEP (don't-care, but this value is fixed).
  - A live redirect (eret&exl, jump, br_taken) is latched by priority into pend_target/pend_eret, with pend_valid<=1.
  - An existing pend_valid=1 is never overwritten; the older redirect wins.
  - state<=HOLD.
- Released cycle (hc=0, no exc_ok):
  - pc_hold=0.
  - If pend_valid: pc_next=pend_target, flush=1, pend_valid<=0. If pend_eret, also exl<=0. Live redirects in this cycle are dropped.
  - Else if eret&exl: pc_next=epc, flush=1, exl<=0.
  - Else if jump: pc_next=jump_target, flush=1.
  - Else if br_taken: pc_next=br_target, flush=1.
  - Else: pc_next=pc_cur+PC_STEP, flush=0.
  - state<=RUN, except from DRAIN (see below).
- eret with exl=0 is ignored and treated as sequential.
- DRAIN: exactly one cycle after exception entry.
  - flush is forced to 1 regardless of other logic.
  - pc_hold and pc_next follow the normal rules.
  - Next state is HOLD if hc, else RUN.
- Arithmetic: pc_cur+PC_STEP is 32-bit modulo. 0xFFFFFFFC+4 wraps to 0 with no flag.
- Targets are used unmodified; no alignment check is performed.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum RUN/HOLD/DRAIN (2 bits)
  - RESET_PC, EXC_VEC and PC_STEP defaults
  - redirect-source encoding used for pend selection
- One natural sub-module, fetch_redirect_mux: combinational priority select of target and is_eret from the live inputs.
- The FSM, pending register and EPC/EXL registers stay in fetch_seq.

Test Plan:
1. Release reset with pc_cur=0x3000, all requests 0, imem_ready=1 -> pc_next=0x3004, pc_hold=0, flush=0, state=RUN.
2. stall=1 with br_taken=1, br_target=0x3040 for one cycle, stall held 3 cycles, then stall=0 -> pc_hold=1 and state=HOLD for 3 cycles. On release pc_next=0x3040, flush=1, and pend_valid is cleared next cycle.
3. stall=1, exc_req=1, exc_pc=0x3010 -> same cycle pc_next=0x4180, pc_hold=0, flush=1. Next cycle epc=0x3010, exl=1, state=DRAIN, flush=1. The cycle after that, flush=0.
4. exl=1, epc=0x3010: exc_req pulse -> ignored (epc unchanged). Then eret=1 -> pc_next=0x3010, flush=1, and exl=0 next cycle.
5. jump=1 (0x3200) and br_taken=1 (0x3100) in the same cycle -> pc_next=0x3200. Then imem_ready=0 -> pc_hold=1, state=HOLD.
6. Pending jump latched in HOLD, then reset=1 for one cycle -> pc_next=0x3000, flush=1. After reset, stall=0 gives pc_next=pc_cur+4 (the pending target is not used).

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch-stage next-PC sequencer.
//   state_t      : sequencer FSM state (RUN/HOLD/DRAIN), 2 bits
//   redir_src_t  : which live source won the redirect priority select
//   *_DEF        : default reset PC, exception vector and sequential step
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'd0,
    SRC_ERET = 2'd1,
    SRC_JUMP = 2'd2,
    SRC_BR   = 2'd3
  } redir_src_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;

endpackage

// File: rtl/fetch_redirect_mux.sv
// fetch_redirect_mux: combinational priority select among the live redirect
// sources (eret > jump > branch). Exceptions and pending redirects are
// resolved by the caller, above this select.
//   i_eret_ok      : eret while in the handler (already qualified by exl)
//   i_epc          : saved exception PC, the eret target
//   i_jump/_target : resolved jump and its target
//   i_br_taken/_target : resolved taken branch and its target
//   o_valid        : some live redirect is present
//   o_target       : its target address (unmodified)
//   o_is_eret      : the winning redirect is an eret
module fetch_redirect_mux
  import fetch_pkg::*;
(
  input  logic        i_eret_ok,
  input  logic [31:0] i_epc,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic        o_valid,
  output logic [31:0] o_target,
  output logic        o_is_eret
);

  redir_src_t w_src;

  always_comb begin
    w_src = SRC_SEQ;
    if (i_eret_ok)       w_src = SRC_ERET;
    else if (i_jump)     w_src = SRC_JUMP;
    else if (i_br_taken) w_src = SRC_BR;
  end

  always_comb begin
    o_target = 32'd0;
    case (w_src)
      SRC_ERET: o_target = i_epc;
      SRC_JUMP: o_target = i_jump_target;
      SRC_BR:   o_target = i_br_target;
      default:  o_target = 32'd0;
    endcase
  end

  assign o_valid   = (w_src != SRC_SEQ);
  assign o_is_eret = (w_src == SRC_ERET);

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: next-PC sequencer for the fetch stage. Arbitrates exception
// entry, a pending (held-over) redirect, eret, jump, branch and sequential
// fetch; tracks stall / imem wait; owns EPC and EXL.
//   clk, reset        : clock, synchronous active-high reset
//   pc_cur            : current PC from the PC register
//   stall, imem_ready : hold requests (hold = stall | ~imem_ready)
//   br_taken/br_target, jump/jump_target : resolved control transfers
//   exc_req, exc_pc   : exception pulse and faulting PC
//   eret              : return from exception handler
//   pc_next, pc_hold  : PC register data / freeze (combinational)
//   flush             : kill younger in-flight instructions (combinational)
//   epc, exl          : saved exception PC, in-handler flag
//   state             : FSM state RUN=0, HOLD=1, DRAIN=2
module fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        eret,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        flush,
  output logic [31:0] epc,
  output logic        exl,
  output logic [1:0]  state
);

  state_t      r_state;
  logic [31:0] r_epc;
  logic        r_exl;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic        r_pend_eret;

  logic        w_hc;
  logic        w_exc_ok;
  logic        w_eret_ok;
  logic [31:0] w_seq_pc;
  logic        w_live_valid;
  logic [31:0] w_live_target;
  logic        w_live_eret;

  assign w_hc      = stall | ~imem_ready;
  // No nesting: a second exception inside the handler is dropped.
  assign w_exc_ok  = exc_req & ~r_exl;
  assign w_eret_ok = eret & r_exl;
  assign w_seq_pc  = pc_cur + PC_STEP;

  fetch_redirect_mux u_redirect_mux (
    .i_eret_ok     (w_eret_ok),
    .i_epc         (r_epc),
    .i_jump        (jump),
    .i_jump_target (jump_target),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .o_valid       (w_live_valid),
    .o_target      (w_live_target),
    .o_is_eret     (w_live_eret)
  );

  always_comb begin
    pc_next = w_seq_pc;
    pc_hold = 1'b0;
    flush   = 1'b0;
    if (reset) begin
      pc_next = RESET_PC;
      flush   = 1'b1;
    end else if (w_exc_ok) begin
      pc_next = EXC_VEC;
      flush   = 1'b1;
    end else if (w_hc) begin
      pc_hold = 1'b1;
    end else if (r_pend_valid) begin
      pc_next = r_pend_target;
      flush   = 1'b1;
    end else if (w_live_valid) begin
      pc_next = w_live_target;
      flush   = 1'b1;
    end
    // The cycle after exception entry always flushes, whatever else happens.
    if (!reset && r_state == ST_DRAIN) flush = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_epc         <= 32'd0;
      r_exl         <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= 32'd0;
      r_pend_eret   <= 1'b0;
    end else if (w_exc_ok) begin
      r_epc        <= exc_pc;
      r_exl        <= 1'b1;
      r_pend_valid <= 1'b0;
      r_state      <= ST_DRAIN;
    end else if (w_hc) begin
      // Oldest redirect wins: an existing pending entry is never replaced.
      if (!r_pend_valid && w_live_valid) begin
        r_pend_valid  <= 1'b1;
        r_pend_target <= w_live_target;
        r_pend_eret   <= w_live_eret;
      end
      r_state <= ST_HOLD;
    end else begin
      if (r_pend_valid) begin
        r_pend_valid <= 1'b0;
        if (r_pend_eret) r_exl <= 1'b0;
      end else if (w_eret_ok) begin
        r_exl <= 1'b0;
      end
      r_state <= ST_RUN;
    end
  end

  assign epc   = r_epc;
  assign exl   = r_exl;
  assign state = r_state;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  localparam logic [31:0] RPC  = 32'h0000_3000;
  localparam logic [31:0] EVEC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, br_taken, jump, exc_req, eret;
  logic [31:0] pc_cur, br_target, jump_target, exc_pc;
  logic [31:0] pc_next, epc;
  logic        pc_hold, flush, exl;
  logic [1:0]  state;

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .stall       (stall),
    .imem_ready  (imem_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jump        (jump),
    .jump_target (jump_target),
    .exc_req     (exc_req),
    .exc_pc      (exc_pc),
    .eret        (eret),
    .pc_next     (pc_next),
    .pc_hold     (pc_hold),
    .flush       (flush),
    .epc         (epc),
    .exl         (exl),
    .state       (state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state named after the spec's registers.
  logic [31:0] m_epc, m_ptgt;
  bit          m_exl, m_pend, m_peret;
  int          m_state;          // 0 RUN, 1 HOLD, 2 DRAIN
  int          m_live;           // winning live redirect index, -1 none
  bit          m_exc_ok, m_hc;
  logic [31:0] m_cand_tgt [3];
  logic [31:0] e_next;
  bit          e_hold, e_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected combinational outputs from the rule list, given current inputs.
  task automatic model_comb();
    bit cand_v [3];
    cand_v[0] = eret && m_exl;  m_cand_tgt[0] = m_epc;
    cand_v[1] = jump;           m_cand_tgt[1] = jump_target;
    cand_v[2] = br_taken;       m_cand_tgt[2] = br_target;
    m_live = -1;
    for (int i = 2; i >= 0; i--) if (cand_v[i]) m_live = i;
    m_exc_ok = exc_req && !m_exl;
    m_hc     = stall || !imem_ready;
    e_next = pc_cur + 32'd4; e_hold = 0; e_flush = 0;
    if (reset)             begin e_next = RPC;  e_flush = 1; end
    else if (m_exc_ok)     begin e_next = EVEC; e_flush = 1; end
    else if (m_hc)         e_hold = 1;
    else if (m_pend)       begin e_next = m_ptgt; e_flush = 1; end
    else if (m_live >= 0)  begin e_next = m_cand_tgt[m_live]; e_flush = 1; end
    if (!reset && m_state == 2) e_flush = 1;
  endtask

  task automatic model_update();
    if (reset) begin
      m_state = 0; m_epc = 0; m_exl = 0; m_pend = 0; m_ptgt = 0; m_peret = 0;
    end else if (m_exc_ok) begin
      m_epc = exc_pc; m_exl = 1; m_pend = 0; m_state = 2;
    end else if (m_hc) begin
      if (!m_pend && m_live >= 0) begin
        m_pend = 1; m_ptgt = m_cand_tgt[m_live]; m_peret = (m_live == 0);
      end
      m_state = 1;
    end else begin
      if (m_pend) begin
        m_pend = 0;
        if (m_peret) m_exl = 0;
      end else if (m_live == 0) m_exl = 0;
      m_state = 0;
    end
  endtask

  task automatic drive_check(input bit rst, input bit stl, input bit rdy,
                             input bit br, input logic [31:0] bt,
                             input bit jmp, input logic [31:0] jt,
                             input bit exc, input logic [31:0] ep, input bit er);
    reset = rst; stall = stl; imem_ready = rdy; br_taken = br; br_target = bt;
    jump = jmp; jump_target = jt; exc_req = exc; exc_pc = ep; eret = er;
    #1;
    model_comb();
    chk("pc_next", pc_next, e_next);
    chk("pc_hold", 32'(pc_hold), 32'(e_hold));
    chk("flush",   32'(flush),   32'(e_flush));
    chk("epc",     epc,          m_epc);
    chk("exl",     32'(exl),     32'(m_exl));
    chk("state",   32'(state),   32'(m_state));
  endtask

  // Clock the DUT; the bench plays the PC register from the model's outputs.
  task automatic advance();
    @(posedge clk);
    #1;
    model_update();
    if (!e_hold) pc_cur = e_next;
    @(negedge clk);
  endtask

  task automatic idle();
    drive_check(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; stall = 0; imem_ready = 1; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
    br_target = 0; jump_target = 0; exc_pc = 0; pc_cur = 32'hDEAD_BEE0;
    m_state = 0; m_epc = 0; m_exl = 0; m_pend = 0; m_ptgt = 0; m_peret = 0;
    @(negedge clk);
    // Reset outputs; first reset cycle leaves registers unknown, so only outputs.
    reset = 1; #1;
    chk("rst_next",  pc_next, RPC);
    chk("rst_flush", 32'(flush), 32'd1);
    chk("rst_hold",  32'(pc_hold), 32'd0);
    @(posedge clk); #1; pc_cur = RPC; @(negedge clk);
    drive_check(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    advance();

    // 1: out of reset, sequential fetch
    idle();
    chk("t1_next", pc_next, 32'h3004);
    chk("t1_state", 32'(state), 32'd0);
    advance();

    // 2: branch during a 3-cycle stall, released later
    drive_check(0, 1, 1, 1, 32'h3040, 0, 0, 0, 0, 0);
    chk("t2_hold", 32'(pc_hold), 32'd1);
    advance();
    for (int i = 0; i < 2; i++) begin
      drive_check(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("t2_state_hold", 32'(state), 32'd1);
      advance();
    end
    idle();
    chk("t2_rel_next", pc_next, 32'h3040);
    chk("t2_rel_flush", 32'(flush), 32'd1);
    advance();
    idle();
    chk("t2_after_flush", 32'(flush), 32'd0);
    advance();

    // 3: exception overrides stall
    drive_check(0, 1, 1, 0, 0, 0, 0, 1, 32'h3010, 0);
    chk("t3_next", pc_next, EVEC);
    chk("t3_hold", 32'(pc_hold), 32'd0);
    advance();
    idle();
    chk("t3_epc", epc, 32'h3010);
    chk("t3_state", 32'(state), 32'd2);
    chk("t3_drain_flush", 32'(flush), 32'd1);
    advance();
    idle();
    chk("t3_post_flush", 32'(flush), 32'd0);
    advance();

    // 4: nested exception ignored, then eret
    drive_check(0, 0, 1, 0, 0, 0, 0, 1, 32'h3ABC, 0);
    chk("t4_nest_flush", 32'(flush), 32'd0);
    advance();
    drive_check(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    chk("t4_epc", epc, 32'h3010);
    chk("t4_eret_next", pc_next, 32'h3010);
    advance();
    idle();
    chk("t4_exl", 32'(exl), 32'd0);
    advance();

    // 5: jump beats branch, then imem wait
    drive_check(0, 0, 1, 1, 32'h3100, 1, 32'h3200, 0, 0, 0);
    chk("t5_next", pc_next, 32'h3200);
    advance();
    drive_check(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_hold", 32'(pc_hold), 32'd1);
    advance();
    idle();
    chk("t5_state", 32'(state), 32'd1);
    advance();

    // 6: pending jump discarded by reset
    drive_check(0, 1, 1, 0, 0, 1, 32'h3300, 0, 0, 0);
    advance();
    drive_check(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("t6_rst_next", pc_next, 32'h3000);
    chk("t6_rst_flush", 32'(flush), 32'd1);
    advance();
    idle();
    chk("t6_after_next", pc_next, 32'h3004);
    advance();

    // Wrap of the sequential increment
    pc_cur = 32'hFFFF_FFFC;
    idle();
    chk("wrap_next", pc_next, 32'h0);
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(31) == 0) pc_cur = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom;
      drive_check($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(4) != 0,
                  $urandom_range(3) == 0, $urandom, $urandom_range(4) == 0, $urandom,
                  $urandom_range(15) == 0, $urandom, $urandom_range(7) == 0);
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
